sram_rd_streamer: RTL
=====================

SRAM_RD_STREAMER -- requirements
Module: sram_rd_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 512, SRAM row width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, SRAM row count.
REQ-003 SHALL have parameter AW, default 6, SRAM address width.
REQ-004 SHALL have parameter WSB_ACTIVE_HIGH, default 0, write-strobe polarity of the attached SRAM (0: wsb=0 means write).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port start  input  1  one-cycle job request.
REQ-008 SHALL have port base_addr  input  AW  first row of the job.
REQ-009 SHALL have port len  input  AW+1  row count of the job, 0..DEPTH.
REQ-010 SHALL have port busy  output  1  job in progress.
REQ-011 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-012 SHALL have port sram_csb  output  1  SRAM chip select, 0 = enable.
REQ-013 SHALL have port sram_wsb  output  1  SRAM write strobe, held at the non-write level.
REQ-014 SHALL have port sram_raddr  output  AW  SRAM read address.
REQ-015 SHALL have port sram_rdata  input  WIDTH  SRAM read data.
REQ-016 SHALL have ports m_valid output 1, m_ready input 1, m_data output WIDTH, m_last output 1: AXI-style output stream.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with len>0, RUN->DRAIN after the last read is issued, DRAIN->IDLE on the handshake of the beat with m_last=1.
REQ-018 SHALL sample base_addr and len only in the cycle start=1 in IDLE; start outside IDLE SHALL be ignored.
REQ-019 SHALL, on start with len=0, stay in IDLE, issue no read, and pulse done in the following cycle.
REQ-020 SHALL issue a read by driving sram_csb=0 with sram_raddr; sram_csb SHALL be 1 in every cycle without a read.
REQ-021 SHALL treat sram_rdata as valid in the cycle after the read cycle, and capture it at the end of that cycle (fixed 1-cycle SRAM latency).
REQ-022 SHALL generate read addresses base_addr, base_addr+1, ... modulo 2^AW, wrapping from 2^AW-1 to 0.
REQ-023 SHALL buffer captured rows in a 2-entry FIFO feeding m_data; m_valid=1 iff the FIFO is not empty.
REQ-024 SHALL issue a read only when FIFO occupancy plus outstanding reads is <2, counting a same-cycle pop, so no returned row is ever dropped.
REQ-025 SHALL sustain one beat per cycle while m_ready=1 after the first beat; first m_valid SHALL rise 2 cycles after the start cycle.
REQ-026 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-027 SHALL assert m_last on exactly the len-th beat of a job.
REQ-028 SHALL pulse done for one cycle, in the cycle after the m_last handshake; busy SHALL be 1 from the cycle after start through that handshake cycle.
REQ-029 SHALL drive sram_wsb = ~WSB_ACTIVE_HIGH constantly.

Reset
REQ-030 SHALL, with rst=1 at a rising edge, enter IDLE, empty the FIFO, and cancel outstanding reads; rst SHALL take priority over start.
REQ-031 SHALL, during and after reset, output busy=0, done=0, m_valid=0, m_last=0, m_data=0, sram_csb=1, sram_raddr=0.
REQ-032 SHALL, on reset mid-job, discard any SRAM data returning in the next cycle; no done pulse SHALL follow.

Configuration
REQ-033 SHALL, with SRAM_RD_STREAMER_DBG_EN defined, emit a simulation $display warning when a captured sram_rdata contains X, and when start is asserted outside IDLE.
REQ-034 SHALL, without SRAM_RD_STREAMER_DBG_EN defined, contain no debug code; output behaviour is identical in both builds.

Verification
REQ-035 SHALL cover: SRAM row i preloaded with i, start base=0 len=4, m_ready=1 -> beats 0,1,2,3 on consecutive cycles, m_last on beat 3, done one cycle later.
REQ-036 SHALL cover: base=62 len=4, DEPTH=64 -> raddr sequence 62,63,0,1, beats 62,63,0,1.
REQ-037 SHALL cover: len=8 with m_ready toggling 1,0,0,1,... -> all 8 rows in order, none lost or duplicated, m_data stable while stalled, no read issued with 2 rows held.
REQ-038 SHALL cover: start len=0 -> sram_csb stays 1, no m_valid, done pulses the next cycle.
REQ-039 SHALL cover: rst asserted on the 3rd beat of a len=6 job -> outputs at reset values next cycle, no done, then a new len=2 job completes correctly.
REQ-040 SHALL cover: second start while busy -> ignored, first job completes unchanged.

Source files
------------

// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: streams len SRAM rows from base_addr onto an AXI-style output through a 2-entry skid FIFO.
// Define SRAM_RD_STREAMER_DBG_EN to enable simulation warnings for X read data and ignored starts.
module sram_rd_streamer #(
    parameter int WIDTH           = 512,
    parameter int DEPTH           = 64,
    parameter int AW              = 6,
    parameter int WSB_ACTIVE_HIGH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic             sram_csb,
    output logic             sram_wsb,
    output logic [AW-1:0]    sram_raddr,
    input  logic [WIDTH-1:0] sram_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    if (DEPTH > (1 << AW)) begin : g_depth_chk
        $error("DEPTH exceeds the address space of AW");
    end

    state_t           state_q, state_d;
    logic [AW:0]      rem_q, rem_d;
    logic [AW-1:0]    addr_q, addr_d, rd_addr;
    logic             pend_q, pend_last_q, done_q, done_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [1:0]       last_q, cnt_q;
    logic             wp_q, rp_q;
    logic             rd_en, rd_last, pop, room;
    logic [2:0]       occ;

    assign m_valid    = (cnt_q != 2'd0) && !rst;
    assign m_data     = m_valid ? mem_q[rp_q] : '0;
    assign m_last     = m_valid && last_q[rp_q];
    assign pop        = m_valid && m_ready;
    assign busy       = (state_q != IDLE) && !rst;
    assign done       = done_q && !rst;
    assign sram_csb   = rst || !rd_en;
    assign sram_raddr = (rd_en && !rst) ? rd_addr : '0;
    assign sram_wsb   = (WSB_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;
    // A read in flight still needs a slot, so count it alongside held rows.
    assign occ        = {1'b0, cnt_q} + {2'b0, pend_q};
    assign room       = occ < (3'd2 + {2'b0, pop});

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        rd_en   = 1'b0;
        rd_addr = addr_q;
        rd_last = 1'b0;
        done_d  = pop && m_last;
        case (state_q)
            IDLE: if (start) begin
                if (len == '0) begin
                    done_d = 1'b1;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = base_addr;
                    rd_last = (len == (AW+1)'(1));
                    rem_d   = len - (AW+1)'(1);
                    addr_d  = base_addr + AW'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                rd_en   = (rem_q != '0) && room;
                rd_last = (rem_q == (AW+1)'(1));
                if (rd_en) begin
                    rem_d  = rem_q - (AW+1)'(1);
                    addr_d = addr_q + AW'(1);
                end
                state_d = (rem_d == '0) ? DRAIN : RUN;
            end
            DRAIN: state_d = (pop && m_last) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            pend_q      <= rd_en;
            pend_last_q <= rd_last;
            done_q      <= done_d;
            if (pend_q) begin
                mem_q[wp_q]  <= sram_rdata;
                last_q[wp_q] <= pend_last_q;
                wp_q         <= !wp_q;
            end
            if (pop) rp_q <= !rp_q;
            cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end

`ifdef SRAM_RD_STREAMER_DBG_EN
    always @(posedge clk) begin
        if (!rst && pend_q && $isunknown(sram_rdata))
            $display("sram_rd_streamer warning: captured sram_rdata contains X at %0t", $time);
        if (!rst && start && state_q != IDLE)
            $display("sram_rd_streamer warning: start ignored while busy at %0t", $time);
    end
`endif
endmodule
